// File: rtl/rn_freelist_pkg.sv
// Shared widths for the rename free list: PRF tag width, architectural width, pointer width.
`ifndef NCPU_PRF_AW
`define NCPU_PRF_AW 6
`endif

`ifndef NCPU_REG_AW
`define NCPU_REG_AW 5
`endif

package rn_freelist_pkg;

  localparam int unsigned PRF_AW = `NCPU_PRF_AW;
  localparam int unsigned REG_AW = `NCPU_REG_AW;

  localparam int unsigned NP    = 1 << PRF_AW;
  localparam int unsigned NA    = 1 << REG_AW;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned PTR_W = PRF_AW + 1;

endpackage

// File: rtl/rn_freelist_if.sv
// Allocation / commit-free handshake between rename+commit logic and the free list.
interface rn_freelist_if
  import rn_freelist_pkg::*;
#(
  parameter int unsigned IW = 2,
  parameter int unsigned CW = 2,
  parameter int unsigned AW = PRF_AW
) ();

  logic                   flush;
  logic [IW-1:0]          alloc_req;
  logic                   alloc_ready;
  logic [IW-1:0][AW-1:0]  alloc_prd;
  logic [CW-1:0]          cmt_we;
  logic [CW-1:0][AW-1:0]  cmt_opreg;
  logic [AW:0]            free_cnt;

  modport master (
    output flush, alloc_req, cmt_we, cmt_opreg,
    input  alloc_ready, alloc_prd, free_cnt
  );

  modport slave (
    input  flush, alloc_req, cmt_we, cmt_opreg,
    output alloc_ready, alloc_prd, free_cnt
  );

endinterface

// File: rtl/rn_prefix_cnt.sv
// Exclusive prefix popcount of a request vector plus its total population.
module rn_prefix_cnt #(
  parameter  int unsigned N     = 2,
  localparam int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]            vec_i,
  output logic [N-1:0][CNT_W-1:0] pfx_c_o,
  output logic [CNT_W-1:0]        total_c_o
);

  logic [CNT_W-1:0] acc;

  // Running sum: each slot sees the count of set bits strictly below it.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pfx_c_o[i] = acc;
      acc        = acc + CNT_W'(vec_i[i]);
    end
    total_c_o = acc;
  end

endmodule

// File: rtl/rn_freelist.sv
// Physical-register free list: circular tag buffer with speculative head, committed head and tail.
module rn_freelist
  import rn_freelist_pkg::*;
#(
  parameter int unsigned CONFIG_P_ISSUE_WIDTH  = 1,
  parameter int unsigned CONFIG_P_COMMIT_WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  rn_freelist_if.slave bus
);

  localparam int unsigned IW  = 1 << CONFIG_P_ISSUE_WIDTH;
  localparam int unsigned CW  = 1 << CONFIG_P_COMMIT_WIDTH;
  localparam int unsigned ACW = $clog2(IW + 1);
  localparam int unsigned CCW = $clog2(CW + 1);

  logic [PRF_AW-1:0]       tag_q [NP];
  logic [PRF_AW-1:0]       tag_d [NP];
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        chead_q, chead_d;
  logic [PTR_W-1:0]        tail_q, tail_d;

  logic [IW-1:0][ACW-1:0]  a_pfx;
  logic [ACW-1:0]          n_req;
  logic [CW-1:0][CCW-1:0]  c_pfx;
  logic [CCW-1:0]          n_cmt;
  logic [PTR_W-1:0]        free_cnt_c;
  logic                    alloc_fire_c;

  rn_prefix_cnt #(.N(IW)) u_alloc_cnt (
    .vec_i     (bus.alloc_req),
    .pfx_c_o   (a_pfx),
    .total_c_o (n_req)
  );

  rn_prefix_cnt #(.N(CW)) u_cmt_cnt (
    .vec_i     (bus.cmt_we),
    .pfx_c_o   (c_pfx),
    .total_c_o (n_cmt)
  );

  // Allocation view: tags compacted from head in slot order; all-or-nothing readiness.
  always_comb begin
    free_cnt_c      = tail_q - head_q;
    bus.free_cnt    = free_cnt_c;
    bus.alloc_ready = !bus.flush && (free_cnt_c >= PTR_W'(n_req));
    for (int unsigned i = 0; i < IW; i++) begin
      bus.alloc_prd[i] = tag_q[PRF_AW'(head_q + PTR_W'(a_pfx[i]))];
    end
    alloc_fire_c = bus.alloc_ready && (n_req != '0);
  end

  // Pointer and array update; flush rewinds head to the committed head including this cycle's commits.
  always_comb begin
    head_d  = head_q;
    chead_d = chead_q + PTR_W'(n_cmt);
    tail_d  = tail_q + PTR_W'(n_cmt);
    tag_d   = tag_q;
    if (bus.flush) begin
      head_d = chead_q + PTR_W'(n_cmt);
    end else if (alloc_fire_c) begin
      head_d = head_q + PTR_W'(n_req);
    end
    for (int unsigned i = 0; i < CW; i++) begin
      if (bus.cmt_we[i]) begin
        tag_d[PRF_AW'(tail_q + PTR_W'(c_pfx[i]))] = bus.cmt_opreg[i];
      end
    end
  end

  // State registers; reset seeds the list with the non-architectural tags NA..NP-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      chead_q <= '0;
      tail_q  <= PTR_W'(NP - NA);
      for (int unsigned e = 0; e < NP; e++) begin
        tag_q[e] <= (e < NP - NA) ? PRF_AW'(e + NA) : '0;
      end
    end else begin
      head_q  <= head_d;
      chead_q <= chead_d;
      tail_q  <= tail_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_rn_freelist.sv
// Randomised and directed bench for rn_freelist against a queue-based free-list model.
module tb_rn_freelist;
  import rn_freelist_pkg::*;

  localparam int unsigned IW = 2;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rn_freelist_if #(.IW(IW), .CW(CW), .AW(PRF_AW)) bus ();

  rn_freelist #(
    .CONFIG_P_ISSUE_WIDTH  (1),
    .CONFIG_P_COMMIT_WIDTH (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: clist holds the tags from committed head to tail; spec is how many of them are speculatively handed out.
  int clist[$];
  int spec;

  logic [1:0] cur_req, cur_we;
  logic       cur_fl;
  int         cur_op0, cur_op1;

  task automatic model_reset();
    clist.delete();
    for (int t = NA; t < NP; t++) clist.push_back(t);
    spec = 0;
  endtask

  function automatic int exp_free();
    return clist.size() - spec;
  endfunction

  function automatic bit exp_ready();
    return !cur_fl && (exp_free() >= $countones(cur_req));
  endfunction

  function automatic int exp_prd(input int slot);
    int off;
    off = (slot == 1 && cur_req[0]) ? 1 : 0;
    return clist[spec + off];
  endfunction

  // Apply inputs and wait until the combinational outputs settle (falling edge).
  task automatic drive(input logic [1:0] req, input logic fl, input logic [1:0] we,
                       input int op0, input int op1);
    cur_req = req; cur_fl = fl; cur_we = we; cur_op0 = op0; cur_op1 = op1;
    bus.alloc_req    = req;
    bus.flush        = fl;
    bus.cmt_we       = we;
    bus.cmt_opreg[0] = PRF_AW'(op0);
    bus.cmt_opreg[1] = PRF_AW'(op1);
    @(negedge clk);
  endtask

  // Commit the current cycle to the model and move past the next rising edge.
  task automatic advance();
    bit rdy;
    rdy = exp_ready();
    if (rdy) spec += $countones(cur_req);
    if (cur_we[0]) begin void'(clist.pop_front()); spec--; end
    if (cur_we[1]) begin void'(clist.pop_front()); spec--; end
    if (cur_we[0]) clist.push_back(cur_op0);
    if (cur_we[1]) clist.push_back(cur_op1);
    if (cur_fl) spec = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.alloc_req = '0; bus.flush = 1'b0; bus.cmt_we = '0; bus.cmt_opreg = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(2'b00, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.free_cnt !== 7'd32) begin failures++; $display("FAIL reset_free_cnt got=%0d exp=32", bus.free_cnt); end
    checks++;
    if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.alloc_ready); end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    drive(2'b11, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL pair_ready got=%0b exp=1", bus.alloc_ready); end
    checks++;
    if (bus.alloc_prd[0] !== 6'd32) begin failures++; $display("FAIL pair_prd0 got=%0d exp=32", bus.alloc_prd[0]); end
    checks++;
    if (bus.alloc_prd[1] !== 6'd33) begin failures++; $display("FAIL pair_prd1 got=%0d exp=33", bus.alloc_prd[1]); end
    advance();
    drive(2'b00, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.free_cnt !== 7'd30) begin failures++; $display("FAIL pair_free_cnt got=%0d exp=30", bus.free_cnt); end
    advance();
  endtask

  task automatic test_compaction();
    do_reset();
    drive(2'b10, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.alloc_prd[1] !== 6'd32) begin failures++; $display("FAIL compact_slot1 got=%0d exp=32", bus.alloc_prd[1]); end
    advance();
    drive(2'b01, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.free_cnt !== 7'd31) begin failures++; $display("FAIL compact_free_cnt got=%0d exp=31", bus.free_cnt); end
    checks++;
    if (bus.alloc_prd[0] !== 6'd33) begin failures++; $display("FAIL compact_next got=%0d exp=33", bus.alloc_prd[0]); end
    advance();
  endtask

  task automatic test_full_recycle();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(2'b11, 1'b0, 2'b00, 0, 0);
      advance();
    end
    drive(2'b01, 1'b0, 2'b01, 5, 0);
    checks++;
    if (bus.free_cnt !== 7'd0) begin failures++; $display("FAIL full_free_cnt got=%0d exp=0", bus.free_cnt); end
    checks++;
    if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", bus.alloc_ready); end
    advance();
    drive(2'b01, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL recycle_ready got=%0b exp=1", bus.alloc_ready); end
    checks++;
    if (bus.alloc_prd[0] !== 6'd5) begin failures++; $display("FAIL recycle_prd0 got=%0d exp=5", bus.alloc_prd[0]); end
    advance();
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 1'b0, 2'b00, 0, 0);
      advance();
    end
    drive(2'b00, 1'b0, 2'b11, 7, 9);
    advance();
    drive(2'b01, 1'b1, 2'b00, 0, 0);
    checks++;
    if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", bus.alloc_ready); end
    advance();
    drive(2'b01, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.free_cnt !== 7'd32) begin failures++; $display("FAIL flush_free_cnt got=%0d exp=32", bus.free_cnt); end
    checks++;
    if (bus.alloc_prd[0] !== 6'd34) begin failures++; $display("FAIL flush_prd0 got=%0d exp=34", bus.alloc_prd[0]); end
    advance();
  endtask

  task automatic test_flush_commit();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(2'b11, 1'b0, 2'b00, 0, 0);
      advance();
    end
    drive(2'b11, 1'b1, 2'b11, 10, 11);
    checks++;
    if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL flcmt_ready got=%0b exp=0", bus.alloc_ready); end
    checks++;
    if (bus.free_cnt !== 7'd28) begin failures++; $display("FAIL flcmt_free_before got=%0d exp=28", bus.free_cnt); end
    advance();
    drive(2'b11, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.free_cnt !== 7'd32) begin failures++; $display("FAIL flcmt_free_after got=%0d exp=32", bus.free_cnt); end
    checks++;
    if (bus.alloc_prd[0] !== 6'd34) begin failures++; $display("FAIL flcmt_prd0 got=%0d exp=34", bus.alloc_prd[0]); end
    checks++;
    if (bus.alloc_prd[1] !== 6'd35) begin failures++; $display("FAIL flcmt_prd1 got=%0d exp=35", bus.alloc_prd[1]); end
    advance();
    drive(2'b00, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.free_cnt !== 7'd30) begin failures++; $display("FAIL flcmt_free_final got=%0d exp=30", bus.free_cnt); end
    advance();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      drive(2'b11, 1'b0, 2'b00, 0, 0);
      advance();
    end
    drive(2'b00, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.free_cnt !== 7'd10) begin failures++; $display("FAIL arst_pre_free got=%0d exp=10", bus.free_cnt); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.free_cnt !== 7'd32) begin failures++; $display("FAIL arst_immediate_free got=%0d exp=32", bus.free_cnt); end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    drive(2'b11, 1'b0, 2'b00, 0, 0);
    checks++;
    if (bus.alloc_prd[0] !== 6'd32) begin failures++; $display("FAIL arst_prd0 got=%0d exp=32", bus.alloc_prd[0]); end
    checks++;
    if (bus.alloc_prd[1] !== 6'd33) begin failures++; $display("FAIL arst_prd1 got=%0d exp=33", bus.alloc_prd[1]); end
    advance();
  endtask

  task automatic test_random();
    logic [1:0] req, we;
    logic       fl;
    int         ncmt, nmax, op0, op1, exp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req  = 2'($urandom_range(0, 3));
      fl   = ($urandom_range(0, 31) == 0);
      nmax = (spec < 2) ? spec : 2;
      ncmt = $urandom_range(0, nmax);
      if (ncmt == 2)      we = 2'b11;
      else if (ncmt == 1) we = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      else                we = 2'b00;
      op0 = $urandom_range(0, NP - 1);
      op1 = $urandom_range(0, NP - 1);
      drive(req, fl, we, op0, op1);
      checks++;
      if (bus.alloc_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, bus.alloc_ready, exp_ready());
      end
      exp = exp_free();
      checks++;
      if (bus.free_cnt !== 7'(exp)) begin
        failures++; $display("FAIL rand_free_cnt cyc=%0d got=%0d exp=%0d", c, bus.free_cnt, exp);
      end
      if (exp_ready()) begin
        for (int s = 0; s < 2; s++) begin
          if (req[s]) begin
            exp = exp_prd(s);
            checks++;
            if (bus.alloc_prd[s] !== 6'(exp)) begin
              failures++; $display("FAIL rand_prd cyc=%0d slot=%0d got=%0d exp=%0d", c, s, bus.alloc_prd[s], exp);
            end
          end
        end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b0;
    cur_req = '0; cur_we = '0; cur_fl = 1'b0; cur_op0 = 0; cur_op1 = 0;
    model_reset();
    test_reset();
    test_alloc_pair();
    test_compaction();
    test_full_recycle();
    test_flush();
    test_flush_commit();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
